// File: rtl/serial_adder_if.sv
// Handshake/operand bundle for serial_adder: operand intake on one valid/ready pair,
// result delivery on a second. op_sub exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             op_sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin,
`ifdef SERIAL_ADDER_SUB_EN
    output op_sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  op_sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice per clock, LSB first, registered carry.
// Define SERIAL_ADDER_SUB_EN to add op_sub (a - b via ~b and carry-in of 1).
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  serial_adder_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic             r_carry;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_out_valid;
  logic             r_busy;

  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_b_load;
  logic             w_cin_load;

  assign w_s = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
  assign w_c = (r_a_sr[0] & r_b_sr[0]) | (r_a_sr[0] & r_carry) | (r_b_sr[0] & r_carry);

`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_load   = bus.op_sub ? ~bus.b : bus.b;
  assign w_cin_load = bus.op_sub ? 1'b1 : bus.cin;
`else
  assign w_b_load   = bus.b;
  assign w_cin_load = bus.cin;
`endif

  assign bus.in_ready  = (r_state == StIdle);
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_a_sr      <= '0;
      r_b_sr      <= '0;
      r_sum_sr    <= '0;
      r_carry     <= 1'b0;
      r_count     <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.in_valid) begin
            r_a_sr  <= bus.a;
            r_b_sr  <= w_b_load;
            r_carry <= w_cin_load;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= StShift;
          end
        end
        StShift: begin
          r_sum_sr <= {w_s, r_sum_sr[WIDTH-1:1]};
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_carry  <= w_c;
          r_count  <= r_count + 1'b1;
          // Final slice: publish the post-shift sum directly so DONE sees it at once.
          if (r_count == LastBit) begin
            r_sum       <= {w_s, r_sum_sr[WIDTH-1:1]};
            r_cout      <= w_c;
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8); subtract vectors run only
// when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;
  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   n;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns number of rising edges until out_valid is seen.
  task automatic wait_out(output int cnt);
    cnt = 0;
    while (bus.out_valid !== 1'b1 && cnt < 40) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic [7:0] es, input logic ec);
    int lat;
    chk({tag, ".in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, ".busy"}, {31'd0, bus.busy}, 32'd1);
    wait_out(lat);
    chk({tag, ".latency"}, lat, 32'd8);
    chk({tag, ".sum"}, {24'd0, bus.sum}, {24'd0, es});
    chk({tag, ".cout"}, {31'd0, bus.cout}, {31'd0, ec});
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, ".ov_fall"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, ".sum_hold"}, {24'd0, bus.sum}, {24'd0, es});
    chk({tag, ".idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.op_sub    = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst.sum", {24'd0, bus.sum}, 32'd0);
    chk("rst.cout", {31'd0, bus.cout}, 32'd0);
    chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst.busy", {31'd0, bus.busy}, 32'd0);
    chk("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("add5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    do_op("addff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    do_op("addffff1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Backpressure plus an ignored in_valid pulse during SHIFT.
    bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.a = 8'hFF; bus.b = 8'hFF; bus.in_valid = 1'b1;
    chk("bp.shift_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out(n);
    chk("bp.latency", n, 32'd6);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp.out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp.sum", {24'd0, bus.sum}, 32'h47);
      chk("bp.cout", {31'd0, bus.cout}, 32'd0);
      chk("bp.in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("bp.no_second_op", {31'd0, bus.busy}, 32'd0);
    chk("bp.no_second_valid", {31'd0, bus.out_valid}, 32'd0);

    // Reset on the 3rd SHIFT cycle; prior result (47/0) must be wiped.
    bus.a = 8'hAA; bus.b = 8'h55; bus.cin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst.sum", {24'd0, bus.sum}, 32'd0);
    chk("mrst.cout", {31'd0, bus.cout}, 32'd0);
    chk("mrst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mrst.busy", {31'd0, bus.busy}, 32'd0);
    chk("mrst.in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op("post_rst", 8'h01, 8'h02, 1'b1, 8'h04, 1'b0);

    // Back-to-back with in_valid and out_ready held high.
    bus.out_ready = 1'b1;
    bus.cin = 1'b0;
    bus.a = 8'h01; bus.b = 8'h02; bus.in_valid = 1'b1;
    wait_out(n);
    chk("b2b0.latency", n, 32'd9);
    chk("b2b0.sum", {24'd0, bus.sum}, 32'h03);
    chk("b2b0.cout", {31'd0, bus.cout}, 32'd0);
    bus.a = 8'h7F; bus.b = 8'h01;
    @(posedge clk);
    @(negedge clk);
    wait_out(n);
    chk("b2b1.latency", n, 32'd9);
    chk("b2b1.sum", {24'd0, bus.sum}, 32'h80);
    chk("b2b1.cout", {31'd0, bus.cout}, 32'd0);
    bus.a = 8'h80; bus.b = 8'h80;
    @(posedge clk);
    @(negedge clk);
    wait_out(n);
    chk("b2b2.latency", n, 32'd9);
    chk("b2b2.sum", {24'd0, bus.sum}, 32'h00);
    chk("b2b2.cout", {31'd0, bus.cout}, 32'd1);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("b2b.idle", {31'd0, bus.busy}, 32'd0);

`ifdef SERIAL_ADDER_SUB_EN
    bus.op_sub = 1'b1;
    do_op("sub10_01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1);
    do_op("sub01_02", 8'h01, 8'h02, 1'b0, 8'hFF, 1'b0);
    bus.op_sub = 1'b0;
    do_op("nosub", 8'h10, 8'h01, 1'b0, 8'h11, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
